// File: rtl/mips_datapath_alu_mult_div_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_datapath_alu_mult_div_pkg: shared encodings for the iterative mult/div unit
// Rev 1.0
// ---------------------------------------------------------------------------
package mips_datapath_alu_mult_div_pkg;

   localparam int MIPS_WORD_WIDTH = 32;
   localparam int MD_CNT_WIDTH    = $clog2(MIPS_WORD_WIDTH);

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } Mips_Control_Signal_Alu_Signal_MultDivOp;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } md_state_t;

endpackage
`default_nettype wire

// File: rtl/mips_datapath_alu_mult_div_sign.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_datapath_alu_mult_div_sign: operand magnitude extraction and {hi,lo} sign fixup
// Rev 1.0
// ---------------------------------------------------------------------------
module mips_datapath_alu_mult_div_sign #(
   parameter int WIDTH = 32
) (
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   data1,
   input  logic [WIDTH-1:0]   data2,
   output logic [WIDTH-1:0]   mag1,
   output logic [WIDTH-1:0]   mag2,
   output logic               neg1,
   output logic               neg2,
   input  logic [2*WIDTH-1:0] pair_in,
   input  logic               neg_pair,
   input  logic               neg_hi,
   input  logic               neg_lo,
   output logic [2*WIDTH-1:0] pair_out
);

   always_comb begin
      neg1 = is_signed & data1[WIDTH-1];
      neg2 = is_signed & data2[WIDTH-1];
      mag1 = neg1 ? -data1 : data1;
      mag2 = neg2 ? -data2 : data2;
   end

   // Products negate as one 64-bit value; quotient/remainder negate independently.
   always_comb begin
      pair_out = pair_in;
      if (neg_pair) begin
         pair_out = -pair_in;
      end else begin
         if (neg_hi) pair_out[2*WIDTH-1:WIDTH] = -pair_in[2*WIDTH-1:WIDTH];
         if (neg_lo) pair_out[WIDTH-1:0]       = -pair_in[WIDTH-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/mips_datapath_alu_mult_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_datapath_alu_mult_div: iterative MULT/MULTU/DIV/DIVU with HI/LO, MTHI/MTLO
// Optional: MIPS_DATAPATH_ALU_MULT_DIV_EARLY_OUT_EN ends multiplies early. Rev 1.0
// ---------------------------------------------------------------------------
module mips_datapath_alu_mult_div
   import mips_datapath_alu_mult_div_pkg::*;
#(
   parameter int WIDTH = MIPS_WORD_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [MD_CNT_WIDTH-1:0] LAST_ITER = MD_CNT_WIDTH'(WIDTH - 1);
   localparam logic [MD_CNT_WIDTH-1:0] CNT_ONE   = MD_CNT_WIDTH'(1);

   md_state_t               state;
   logic [MD_CNT_WIDTH-1:0] cnt;
   logic [2*WIDTH-1:0]      acc;
   logic [2*WIDTH-1:0]      mcand;
   logic [WIDTH-1:0]        opb;
   logic                    neg_pair, neg_hi, neg_lo;

   logic                    is_signed, neg1, neg2;
   logic [WIDTH-1:0]        mag1, mag2;
   logic [2*WIDTH-1:0]      pair_fixed;
   logic [WIDTH:0]          rem_shift, rem_diff;
   logic                    mul_last;

   assign is_signed = (op == OP_MULT) || (op == OP_DIV);

   mips_datapath_alu_mult_div_sign #(.WIDTH(WIDTH)) u_sign (
      .is_signed (is_signed),
      .data1     (data1),
      .data2     (data2),
      .mag1      (mag1),
      .mag2      (mag2),
      .neg1      (neg1),
      .neg2      (neg2),
      .pair_in   (acc),
      .neg_pair  (neg_pair),
      .neg_hi    (neg_hi),
      .neg_lo    (neg_lo),
      .pair_out  (pair_fixed)
   );

   // Restoring division: acc holds {remainder, dividend bits shifting into quotient}.
   assign rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign rem_diff  = rem_shift - {1'b0, opb};

`ifdef MIPS_DATAPATH_ALU_MULT_DIV_EARLY_OUT_EN
   assign mul_last = (opb[WIDTH-1:1] == '0);
`else
   assign mul_last = (cnt == LAST_ITER);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         cnt      <= '0;
         acc      <= '0;
         mcand    <= '0;
         opb      <= '0;
         neg_pair <= 1'b0;
         neg_hi   <= 1'b0;
         neg_lo   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        state    <= ST_MUL;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        acc      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, mag1};
                        opb      <= mag2;
                        neg_pair <= neg1 ^ neg2;
                        neg_hi   <= 1'b0;
                        neg_lo   <= 1'b0;
                     end
                     OP_DIV, OP_DIVU: begin
                        state    <= ST_DIV;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        acc      <= {{WIDTH{1'b0}}, mag1};
                        opb      <= mag2;
                        neg_pair <= 1'b0;
                        neg_hi   <= neg1;
                        // divide-by-zero keeps the all-ones quotient regardless of sign
                        neg_lo   <= (neg1 ^ neg2) && (data2 != '0);
                     end
                     OP_MTHI: hi <= data1;
                     OP_MTLO: lo <= data1;
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               if (opb[0]) acc <= acc + mcand;
               mcand <= mcand << 1;
               opb   <= opb >> 1;
               cnt   <= cnt + CNT_ONE;
               if (mul_last) state <= ST_FIX;
            end
            ST_DIV: begin
               if (!rem_diff[WIDTH]) acc <= {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               else                  acc <= {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
               cnt <= cnt + CNT_ONE;
               if (cnt == LAST_ITER) state <= ST_FIX;
            end
            ST_FIX: begin
               hi    <= pair_fixed[2*WIDTH-1:WIDTH];
               lo    <= pair_fixed[WIDTH-1:0];
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_datapath_alu_mult_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_datapath_alu_mult_div: directed self-checking bench for the mult/div unit
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mips_datapath_alu_mult_div;
   import mips_datapath_alu_mult_div_pkg::*;

`ifdef MIPS_DATAPATH_ALU_MULT_DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] data1 = '0;
   logic [31:0] data2 = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_datapath_alu_mult_div #(.WIDTH(32)) dut (
      .clock (clk),
      .reset (rst),
      .start (start),
      .op    (op),
      .data1 (data1),
      .data2 (data2),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Issue one mult/div, optionally poke a second start at edge inj_at, and check all results.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int lat_fixed, input int lat_early, input int inj_at);
      int k;
      int busy_cnt;
      int exp_lat;
      logic [31:0] hi0, lo0;
      exp_lat = EARLY ? lat_early : lat_fixed;
      hi0 = hi;
      lo0 = lo;
      @(negedge clk);
      start = 1'b1; op = o; data1 = a; data2 = b;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      busy_cnt = 0;
      while (!done && k < 100) begin
         if (busy) busy_cnt++;
         if (k == 1) begin
            check({tag, "_hold_hi"}, hi, hi0);
            check({tag, "_hold_lo"}, lo, lo0);
         end
         if (k == inj_at) begin
            start = 1'b1; op = OP_DIVU; data1 = 32'd100; data2 = 32'd7;
         end
         if (k == inj_at + 1) start = 1'b0;
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
      check({tag, "_latency"}, k, exp_lat);
      check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("rst_hi", hi, 32'd0);
         check("rst_lo", lo, 32'd0);
         check("rst_busy", {31'd0, busy}, 32'd0);
         check("rst_done", {31'd0, done}, 32'd0);
         @(posedge clk); #1;
      end

      run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 33, -1);
      run_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33, 4, -1);
      run_op("mult_nn",   OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, 2, -1);
      run_op("divu",      OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, 33, -1);
      run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33, -1);
      run_op("div_negd",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 33, -1);
      run_op("divu_big",  OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 33, 33, -1);
      run_op("div_zero",  OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33, 33, -1);
      run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33, 33, -1);
      run_op("multu_5x3", OP_MULTU, 32'd5,        32'd3,        32'd0,        32'd15,       33, 3, -1);
      run_op("mult_busy", OP_MULT,  32'h1234,     32'h10,       32'd0,        32'h12340,    33, 6, 4);

      // Reset during an operation
      @(negedge clk);
      start = 1'b1; op = OP_MULTU; data1 = 32'hFFFF; data2 = 32'hFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 check("abort_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);

      // MTHI / MTLO single-edge writes
      @(negedge clk);
      start = 1'b1; op = OP_MTHI; data1 = 32'h1234; data2 = 32'h0;
      @(posedge clk); #1;
      start = 1'b0;
      check("mthi_hi", hi, 32'h1234);
      check("mthi_lo", lo, 32'd0);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      check("mthi_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      start = 1'b1; op = OP_MTLO; data1 = 32'hCAFE0001;
      @(posedge clk); #1;
      start = 1'b0;
      check("mtlo_lo", lo, 32'hCAFE0001);
      check("mtlo_hi", hi, 32'h1234);
      check("mtlo_busy", {31'd0, busy}, 32'd0);

      // Undefined encoding leaves everything untouched
      @(negedge clk);
      start = 1'b1; op = 3'd7; data1 = 32'hDEADBEEF;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("undef_busy", {31'd0, busy}, 32'd0);
         check("undef_hi", hi, 32'h1234);
         check("undef_lo", lo, 32'hCAFE0001);
         @(posedge clk); #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mips_datapath_alu_mult_div.md
Name: mips_datapath_alu_mult_div

Overview:
Iterative multiply/divide unit in the EX stage, directly downstream of the ALU operand muxes. It consumes the selected data1/data2 operands and owns the architectural HI/LO registers. Executes MULT, MULTU, DIV, DIVU as multi-cycle operations and MTHI/MTLO as single-cycle writes. Raises busy so the hazard unit stalls IF/ID/EX while an operation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width; must equal the Mips word width.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
start  input  1  request; accepted only while busy=0
op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO (package constants)
data1  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
data2  input  WIDTH  rt operand (multiplier / divisor)
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse when HI/LO are updated by a mult/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0; reset mid-operation aborts, discarding partial results.
- States: IDLE -> MUL or DIV on accept; MUL/DIV -> FIX after final iteration; FIX -> IDLE.
- Accept edge E0 (start=1, busy=0): latch |data1|, |data2| and result signs (unsigned ops: magnitude = raw value, sign = positive).
- Iterations on E1..E32: one shift-add bit (MUL) or one restoring-subtract bit (DIV) per edge; counter 0..31.
- E33 (FIX): apply sign correction, write hi/lo; state -> IDLE; done=1 for the cycle following E33 only; busy=0 in that same cycle.
- busy=1 in cycles following E0..E32 (33 cycles).
- hi/lo hold previous values throughout an operation.
- MULT/MULTU: {hi,lo} = 64-bit product; signed result negated when operand signs differ.
- DIV/DIVU: lo = quotient truncated toward zero; hi = remainder, sign follows dividend.
- Divide by zero (data2=0): full latency; lo=0xFFFFFFFF, hi=data1; no exception.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrapping).
- MTHI/MTLO: write hi (resp. lo) at E0 from data1; state stays IDLE; busy and done stay 0.
- start while busy=1: ignored, no effect on state or operands.
- Undefined op encodings: ignored.

Optional Feature:
Macro MIPS_DATAPATH_ALU_MULT_DIV_EARLY_OUT_EN.
- Defined: multiplies run n = max(1, bit index of highest set bit of |multiplier| + 1) iterations, then FIX. Total latency is n+1 edges after E0. Divides are unchanged.
- Undefined: every multiply takes the fixed 32 iterations.

Decomposition:
- Shared package: op encodings (Mips_Control_Signal_Alu_Signal_MultDivOp), state encoding, WIDTH-derived iteration counter width.
- One sub-module: mips_datapath_alu_mult_div_sign. Combinational magnitude extraction at accept and two's-complement fixup of the {hi,lo} pair at FIX, reused by mult and div.

Test Plan:
- Reset, then idle 5 cycles -> hi=0, lo=0, busy=0, done=0 throughout.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy for 33 cycles, done pulse once; hi=0xFFFFFFFE, lo=0x00000001. MULT 0xFFFFFFFD*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU 100/7 -> lo=14, hi=2. DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 5/0 -> lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT in flight, start DIVU at iteration 4 -> ignored, MULT result correct. Reset at iteration 10 -> busy=0, hi=lo=0 next cycle. MTHI 0x1234 -> hi=0x1234 after one edge, busy never 1.
- With EARLY_OUT_EN: MULTU 5*3 -> done after 3 edges past accept, lo=15. Without the macro: the same multiply takes 33 edges.
